// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and the iterative M-extension engine.
// Holds base ALU operation codes, alu_op encodings, RV32M funct3 codes and the MDU FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step per cycle on magnitudes.
// o_done is high during the final iteration; o_result then carries the sign-corrected answer.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_count;
  logic [2:0]      r_op;
  logic            r_busy;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  // Operand sign handling: MULHU/DIVU/REMU are fully unsigned, MULHSU treats only rs1 as signed.
  always_comb begin
    w_a_signed = !(i_op == MD_MULHU || i_op == MD_DIVU || i_op == MD_REMU);
    w_b_signed = (i_op == MD_MUL || i_op == MD_MULH || i_op == MD_DIV || i_op == MD_REM);
    w_a_neg    = w_a_signed & i_a[XLEN-1];
    w_b_neg    = w_b_signed & i_b[XLEN-1];
    w_a_mag    = w_a_neg ? (-i_a) : i_a;
    w_b_mag    = w_b_neg ? (-i_b) : i_b;
  end

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_shift;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_hi_next;
  logic [XLEN-1:0]   w_lo_next;

  // Divide keeps the partial remainder in r_hi and the quotient shifting into r_lo;
  // multiply keeps the growing product in {r_hi, r_lo} with the multiplier draining out of r_lo.
  always_comb begin
    w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rem_shift = {r_hi, r_lo[XLEN-1]};
    w_diff      = w_rem_shift - {1'b0, r_b};
    w_hi_next   = w_sum[XLEN:1];
    w_lo_next   = {w_sum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_hi_next = w_diff[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_next = w_rem_shift[XLEN-1:0];
        w_lo_next = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  always_comb begin
    w_prod   = r_neg_q ? (-{w_hi_next, w_lo_next}) : {w_hi_next, w_lo_next};
    w_quot   = r_neg_q ? (-w_lo_next) : w_lo_next;
    w_rem    = r_neg_r ? (-w_hi_next) : w_hi_next;
    o_result = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      MD_MUL:           o_result = w_prod[XLEN-1:0];
      MD_DIV, MD_DIVU:  o_result = w_quot;
      MD_REM, MD_REMU:  o_result = w_rem;
      default:          o_result = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  assign o_done = r_busy && (r_count == CW'(XLEN - 1));

  // Start loads magnitudes; the divider reuses r_lo for the dividend, the multiplier for the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= MD_MUL;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_op    <= i_op;
      r_hi    <= '0;
      r_lo    <= i_op[2] ? w_a_mag : w_b_mag;
      r_b     <= i_op[2] ? w_b_mag : w_a_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (r_busy) begin
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_count <= r_count + 1'b1;
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decoder with RV32M decode and a stalling iterative multiply/divide engine.
// Divide-by-zero and signed-overflow divides bypass the iterative engine and finish in one cycle.
module alu_mdu_control
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            r_type,
  input  logic            valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      alu_ctrl,
  output logic            md_op,
  output logic            stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_done
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  assign md_op = ENABLE_M && (alu_op == ALUOP_FUNCT) && r_type && funct7_0;

  // Only register-register SUB uses funct7_5 at funct3 000; ADDI immediates may set that bit.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_LUI: alu_ctrl = ALU_ADD;
      default: begin
        if (md_op) begin
          alu_ctrl = ALU_ADD;
        end else begin
          case (funct3)
            3'b000:  alu_ctrl = (r_type && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
          endcase
        end
      end
    endcase
  end

  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;

  // funct3[1] selects remainder, funct3[0] selects unsigned among the divide ops.
  always_comb begin
    w_div_zero       = (rs2 == '0);
    w_overflow       = !funct3[0] && (rs1 == MIN_INT) && (rs2 == '1);
    w_special        = funct3[2] && (w_div_zero || w_overflow);
    w_special_result = funct3[1] ? '0 : MIN_INT;
    if (w_div_zero) w_special_result = funct3[1] ? rs1 : '1;
  end

  md_state_e       r_state;
  logic [XLEN-1:0] r_md_result;
  logic            r_md_done;
  logic            w_start;
  logic            w_iter_done;
  logic [XLEN-1:0] w_iter_result;

  assign w_start = (r_state == ST_IDLE) && valid && md_op && !w_special;

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_op     (funct3),
    .i_a      (rs1),
    .i_b      (rs2),
    .o_done   (w_iter_done),
    .o_result (w_iter_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_md_result <= '0;
      r_md_done   <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid && md_op) begin
            if (w_special) begin
              r_md_result <= w_special_result;
              r_md_done   <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (w_iter_done) begin
            r_md_result <= w_iter_result;
            r_md_done   <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the accept cycle and every iteration; DONE releases the pipeline.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      ST_IDLE: stall = valid && md_op;
      ST_BUSY: stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign md_result = r_md_result;
  assign md_done   = r_md_done;

endmodule

// File: tb/tb_alu_mdu_control.sv
// Scoreboard bench for alu_mdu_control: base decode table, M-extension ops, special cases, reset abort.
// Stimulus queues expected results; a negedge monitor pops them on md_done and checks result and stall length.
module tb_alu_mdu_control;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        funct7_0;
  logic        r_type;
  logic        valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  alu_ctrl;
  logic        md_op;
  logic        stall;
  logic [31:0] md_result;
  logic        md_done;

  alu_mdu_control #(
    .XLEN(32),
    .ENABLE_M(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .r_type    (r_type),
    .valid     (valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .alu_ctrl  (alu_ctrl),
    .md_op     (md_op),
    .stall     (stall),
    .md_result (md_result),
    .md_done   (md_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] result;
    int          stalls;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monExp;
  int          checks = 0;
  int          errors = 0;
  int          stallCnt = 0;
  logic [10:0] decTab [22];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: counts stall-high cycles per operation and scores each md_done pulse.
  always @(negedge clk) begin
    if (rst) begin
      stallCnt = 0;
    end else if (md_done) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got md_done=1 result 0x%08h, expected no completion", md_result);
      end else begin
        monExp = expQ.pop_front();
        checkOutput({monExp.name, "_result"}, md_result, monExp.result);
        checkOutput({monExp.name, "_stalls"}, 32'(stallCnt), 32'(monExp.stalls));
      end
      stallCnt = 0;
    end else if (stall) begin
      stallCnt++;
    end
  end

  task automatic applyStimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expRes, input int expStalls);
    bit done;
    alu_op   = ALUOP_FUNCT;
    funct3   = f3;
    funct7_5 = 1'b0;
    funct7_0 = 1'b1;
    r_type   = 1'b1;
    rs1      = a;
    rs2      = b;
    valid    = 1'b1;
    expQ.push_back('{name, expRes, expStalls});
    #1;
    checkOutput({name, "_md_op"}, 32'(md_op), 32'd1);
    checkOutput({name, "_alu_ctrl"}, 32'(alu_ctrl), 32'(ALU_ADD));
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (md_done) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no md_done in 100 cycles, expected md_done", name);
      expQ.delete();
    end
    @(posedge clk);
    #1;
    valid    = 1'b0;
    funct7_0 = 1'b0;
    r_type   = 1'b0;
    alu_op   = ALUOP_ADD;
  endtask

  initial begin
    // {alu_op, funct3, funct7_5, r_type, expected alu_ctrl}
    decTab = '{
      {2'b00, 3'b000, 1'b0, 1'b0, ALU_ADD},  {2'b00, 3'b111, 1'b1, 1'b1, ALU_ADD},
      {2'b01, 3'b000, 1'b0, 1'b0, ALU_SUB},  {2'b01, 3'b101, 1'b1, 1'b1, ALU_SUB},
      {2'b11, 3'b000, 1'b0, 1'b0, ALU_ADD},  {2'b11, 3'b010, 1'b1, 1'b0, ALU_ADD},
      {2'b10, 3'b000, 1'b0, 1'b1, ALU_ADD},  {2'b10, 3'b000, 1'b1, 1'b1, ALU_SUB},
      {2'b10, 3'b000, 1'b1, 1'b0, ALU_ADD},  {2'b10, 3'b000, 1'b0, 1'b0, ALU_ADD},
      {2'b10, 3'b001, 1'b0, 1'b1, ALU_SLL},  {2'b10, 3'b001, 1'b0, 1'b0, ALU_SLL},
      {2'b10, 3'b010, 1'b0, 1'b1, ALU_SLT},  {2'b10, 3'b011, 1'b0, 1'b1, ALU_SLTU},
      {2'b10, 3'b100, 1'b0, 1'b1, ALU_XOR},  {2'b10, 3'b101, 1'b0, 1'b1, ALU_SRL},
      {2'b10, 3'b101, 1'b1, 1'b1, ALU_SRA},  {2'b10, 3'b101, 1'b1, 1'b0, ALU_SRA},
      {2'b10, 3'b101, 1'b0, 1'b0, ALU_SRL},  {2'b10, 3'b110, 1'b0, 1'b1, ALU_OR},
      {2'b10, 3'b111, 1'b0, 1'b1, ALU_AND},  {2'b10, 3'b111, 1'b0, 1'b0, ALU_AND}
    };

    rst      = 1'b1;
    valid    = 1'b0;
    alu_op   = ALUOP_ADD;
    funct3   = 3'b000;
    funct7_5 = 1'b0;
    funct7_0 = 1'b0;
    r_type   = 1'b0;
    rs1      = '0;
    rs2      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_md_done", 32'(md_done), 32'd0);
    checkOutput("reset_md_result", md_result, 32'd0);

    for (int i = 0; i < 22; i++) begin
      alu_op   = decTab[i][10:9];
      funct3   = decTab[i][8:6];
      funct7_5 = decTab[i][5];
      r_type   = decTab[i][4];
      #1;
      checkOutput($sformatf("decode_%0d", i), 32'(alu_ctrl), 32'(decTab[i][3:0]));
    end
    // OP-IMM with instr[25] set is a shift immediate, not an M op.
    alu_op   = ALUOP_FUNCT;
    funct3   = 3'b001;
    funct7_5 = 1'b0;
    funct7_0 = 1'b1;
    r_type   = 1'b0;
    #1;
    checkOutput("opimm_md_op", 32'(md_op), 32'd0);
    checkOutput("opimm_alu_ctrl", 32'(alu_ctrl), 32'(ALU_SLL));
    funct7_0 = 1'b0;
    alu_op   = ALUOP_ADD;
    @(posedge clk);
    #1;

    applyStimulus("mul",      MD_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    applyStimulus("mulhu",    MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    applyStimulus("mulh",     MD_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33);
    applyStimulus("mulhsu",   MD_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33);
    applyStimulus("div",      MD_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
    applyStimulus("rem",      MD_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
    applyStimulus("divu_z",   MD_DIVU,   32'd9,          32'd0,        32'hFFFFFFFF, 1);
    applyStimulus("rem_z",    MD_REM,    32'd5,          32'd0,        32'd5,        1);
    applyStimulus("div_ovf",  MD_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
    applyStimulus("rem_ovf",  MD_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1);
    applyStimulus("remu",     MD_REMU,   32'd100,        32'd7,        32'd2,        33);

    repeat (3) @(negedge clk);
    checkOutput("hold_md_result", md_result, 32'd2);
    checkOutput("hold_md_done", 32'(md_done), 32'd0);

    // Abort an in-flight DIVU in BUSY cycle 10; it must never complete.
    @(posedge clk);
    #1;
    alu_op   = ALUOP_FUNCT;
    funct3   = MD_DIVU;
    funct7_0 = 1'b1;
    r_type   = 1'b1;
    rs1      = 32'd1000;
    rs2      = 32'd3;
    valid    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_busy_stall", 32'(stall), 32'd1);
    rst   = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_stall", 32'(stall), 32'd0);
    checkOutput("abort_md_done", 32'(md_done), 32'd0);
    checkOutput("abort_md_result", md_result, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus("divu_after_rst", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);

    repeat (40) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu_control.md
Name: alu_mdu_control

Overview:
- Successor to the single-cycle ALU control decoder for the simple RV32 core.
- Keeps the combinational base ALU control mapping.
- Adds RV32M decode and an iterative multiply/divide engine, parametrised in XLEN.
- Sits in EX beside the ALU and drives a pipeline stall while a MUL/DIV/REM operation is in flight.

Parameters:
XLEN, 32, datapath width of operands and result (power of two, ≥8).
ENABLE_M, 1, 0 removes the M engine: md_op is forced to 0 and md_result/md_done/stall tie to 0.

Ports:
clk  in  1  clock
rst  in  1  reset
alu_op  in  2  00 ADD, 01 SUB, 10 funct decode, 11 ADD (LUI/AUIPC)
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
funct7_0  in  1  instr[25]
r_type  in  1  1 for the OP opcode (register-register); 0 for OP-IMM and all other opcodes
valid  in  1  EX stage holds a live instruction
rs1  in  XLEN  operand A
rs2  in  XLEN  operand B
alu_ctrl  out  4  base ALU operation code
md_op  out  1  current instruction is an M-extension operation
stall  out  1  hold IF/ID/EX; valid, rs1, rs2 and funct fields stay stable while high
md_result  out  XLEN  M-extension result
md_done  out  1  one-cycle pulse; md_result valid

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- alu_ctrl (combinational) codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - alu_op 00 → ADD; alu_op 01 → SUB; alu_op 11 → ADD.
  - alu_op 10 decodes funct3: 000 → SUB if (r_type & funct7_5) else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 → SRA if funct7_5 else SRL; 110 OR; 111 AND.
  - funct3 000 with funct7_5 set and r_type=0 (ADDI) → ADD.
- md_op = ENABLE_M & alu_op==10 & r_type & funct7_0. When md_op=1, alu_ctrl = ADD (0000).
- FSM states: IDLE, BUSY, DONE. Reset → IDLE, md_result=0, md_done=0, counter=0.
- IDLE:
  - If valid & md_op and the operation is a special case: register the special result, go to DONE. stall=1 for this cycle.
  - Otherwise, if valid & md_op: latch rs1, rs2 and funct3 (sign handling per op); counter=0; go BUSY. stall=1.
  - Otherwise stall=0.
- BUSY:
  - stall=1.
  - One iteration per cycle: shift-add multiply (2·XLEN product) or restoring divide on absolute values.
  - Exactly XLEN iterations, then go to DONE with sign correction applied.
- DONE:
  - stall=0, md_done=1, md_result valid. Next state is always IDLE.
  - The pipeline advances on this edge, so the same instruction never restarts.
- Latency:
  - Normal op: stall high for XLEN+1 cycles; md_done in cycle XLEN+1 counted from first acceptance (cycle 0).
  - Special case: stall high for 1 cycle; md_done in cycle 1.
- funct3 results:
  - MUL: low XLEN of signed product.
  - MULH: high XLEN, signed×signed.
  - MULHSU: high XLEN, signed×unsigned.
  - MULHU: high XLEN, unsigned×unsigned.
  - DIV/DIVU: quotient, truncated toward zero.
  - REM/REMU: remainder; sign follows the dividend.
- Special cases:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1=MIN_INT, rs2=all ones): DIV → MIN_INT; REM → 0.
- md_result holds its value until the next completion.
- rst asserted in any state: next state IDLE, engine aborted, md_done=0, md_result=0; the in-flight operation is discarded.
- valid dropping during BUSY is illegal (the pipeline is stalled) and is not checked.

Decomposition:
- Shared package alu_pkg:
  - ALU_* 4-bit codes.
  - ALUOP_* 2-bit codes.
  - MD_* funct3 codes: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
  - FSM state typedef.
- One sub-module, mdu_iter: the iterative mul/div datapath with start/done handshake and counter.
- alu_mdu_control keeps the decode logic and the FSM.

Test Plan (XLEN=32):
- Base map regression: all 22 existing base-decode cases return identical alu_ctrl. alu_op=10, funct3=000, funct7_5=1, r_type=0 → ADD (0000).
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), funct3=000, funct7_0=1, r_type=1, valid=1 → stall high 33 cycles, md_done in cycle 33, md_result=0xFFFFFFEB. Also check alu_ctrl=0000 and md_op=1.
- MULHU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → md_result=0xFFFFFFFE. MULH with the same operands → 0x00000000.
- DIV/REM signed: rs1=-7, rs2=2 → DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1).
- Special cases, each with 1-cycle stall and md_done in cycle 1:
  - DIVU by 0 → 0xFFFFFFFF.
  - REM by 0 with rs1=5 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- Reset mid-op: assert rst in BUSY cycle 10 → next cycle stall=0, md_done=0, md_result=0. After releasing rst, re-issue DIVU 100/7 → 14 after 33 stall cycles.
